// File: rtl/shift_receiver_pkg.sv
// ============================================================================
// Module : shift_receiver_pkg
// Brief  : Shared FSM state type and serial line levels for the receiver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package shift_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic LINE_IDLE = 1'b0;
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/sipo_register.sv
// ============================================================================
// Module : sipo_register
// Brief  : MSB-first serial-in/parallel-out shift register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sipo_register #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  shift_enable,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] parallel_out
);

    logic [DATA_WIDTH-1:0] r_shift;

    // First bit received ends up in the MSB after DATA_WIDTH shifts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
        end else if (shift_enable) begin
            r_shift <= {r_shift[DATA_WIDTH-2:0], serial_in};
        end
    end

    assign parallel_out = r_shift;

endmodule

`default_nettype wire

// File: rtl/shift_receiver.sv
// ============================================================================
// Module : shift_receiver
// Brief  : Framed serial-to-parallel receiver with valid/read handshake and
//          frame/overrun/parity error pulses. Parity: SHIFT_RECEIVER_PARITY_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shift_receiver
    import shift_receiver_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_error,
    output logic                  overrun_error,
    output logic                  parity_error
);

    state_t                  r_state;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    logic                    r_frame_err;
    logic                    r_overrun;
    logic [DATA_WIDTH-1:0]   w_word;
    logic                    w_shift_en;
    logic                    w_last_bit;
    logic                    w_stop_ok;
    logic                    w_accept;

    assign w_shift_en = (r_state == DATA);
    assign w_last_bit = (r_count == COUNT_WIDTH'(DATA_WIDTH - 1));
    assign w_stop_ok  = (serial_in == STOP_BIT);
    // A read on the completing edge frees the holding register for the new word.
    assign w_accept   = !r_valid || read_enable;

    sipo_register #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sipo (
        .clk          (clk),
        .reset        (reset),
        .shift_enable (w_shift_en),
        .serial_in    (serial_in),
        .parallel_out (w_word)
    );

`ifdef SHIFT_RECEIVER_PARITY_EN
    logic r_parity_bad;
    logic r_parity_err;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef SHIFT_RECEIVER_PARITY_EN
            r_parity_bad <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef SHIFT_RECEIVER_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (read_enable && r_valid) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (serial_in == START_BIT) begin
                        r_state <= DATA;
                        r_count <= '0;
                    end
                end
                DATA: begin
                    r_count <= r_count + COUNT_WIDTH'(1);
                    if (w_last_bit) begin
`ifdef SHIFT_RECEIVER_PARITY_EN
                        r_state <= PARITY;
`else
                        r_state <= STOP;
`endif
                    end
                end
`ifdef SHIFT_RECEIVER_PARITY_EN
                PARITY: begin
                    // Even parity: data plus parity bit must XOR to zero.
                    r_parity_bad <= ^{w_word, serial_in};
                    r_state      <= STOP;
                end
`endif
                STOP: begin
                    r_state <= IDLE;
                    if (!w_stop_ok) begin
                        r_frame_err <= 1'b1;
`ifdef SHIFT_RECEIVER_PARITY_EN
                    end else if (r_parity_bad) begin
                        r_parity_err <= 1'b1;
`endif
                    end else if (w_accept) begin
                        r_data  <= w_word;
                        r_valid <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_out      = r_data;
    assign data_valid    = r_valid;
    assign frame_error   = r_frame_err;
    assign overrun_error = r_overrun;
`ifdef SHIFT_RECEIVER_PARITY_EN
    assign parity_error  = r_parity_err;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_receiver.sv
// ============================================================================
// Module : tb_shift_receiver
// Brief  : Scoreboard bench: words queued as frames are sent, compared on read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_shift_receiver;
    import shift_receiver_pkg::*;

    localparam int DW = 8;
`ifdef SHIFT_RECEIVER_PARITY_EN
    localparam int FRAME_LEN = DW + 3;
`else
    localparam int FRAME_LEN = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          serial_in;
    logic          read_enable;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          frame_error;
    logic          overrun_error;
    logic          parity_error;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    logic [DW-1:0] exp_q[$];

    shift_receiver #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .read_enable   (read_enable),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .frame_error   (frame_error),
        .overrun_error (overrun_error),
        .parity_error  (parity_error)
    );

    always #5 clk = ~clk;

    // Error pulse accounting and read-side scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_error)   fe_cnt++;
            if (overrun_error) ov_cnt++;
            if (parity_error)  pe_cnt++;
            if (read_enable && data_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_read: got %h, expected no word", data_out);
                end else begin
                    logic [DW-1:0] exp_w;
                    exp_w = exp_q.pop_front();
                    if (data_out !== exp_w) begin
                        errors++;
                        $display("FAIL scoreboard_read: got %h, expected %h", data_out, exp_w);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        serial_in = LINE_IDLE;
        repeat (n) step();
    endtask

    task automatic read_word();
        serial_in   = LINE_IDLE;
        read_enable = 1'b1;
        step();
        read_enable = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] data, input logic stop_bit,
                              input logic par_ok, input int read_at,
                              input logic expect_load);
        logic b[FRAME_LEN];
        logic pbit;
        pbit = par_ok ? ^data : ~(^data);
        b[0] = START_BIT;
        for (int i = 0; i < DW; i++) b[1+i] = data[DW-1-i];
`ifdef SHIFT_RECEIVER_PARITY_EN
        b[DW+1] = pbit;
`endif
        b[FRAME_LEN-1] = stop_bit;
        if (expect_load) exp_q.push_back(data);
        for (int k = 0; k < FRAME_LEN; k++) begin
            serial_in = b[k];
            if (k == read_at) read_enable = 1'b1;
            step();
            read_enable = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; serial_in = LINE_IDLE; read_enable = 1'b0;
        repeat (3) step();
        checks++;
        if ({data_out, data_valid} !== {DW'(0), 1'b0}) begin
            errors++;
            $display("FAIL reset_data: got %h/%b, expected 00/0", data_out, data_valid);
        end
        checks++;
        if ({frame_error, overrun_error, parity_error} !== 3'b000) begin
            errors++;
            $display("FAIL reset_errors: got %b, expected 000",
                     {frame_error, overrun_error, parity_error});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int fe0 = fe_cnt, ov0 = ov_cnt, pe0 = pe_cnt;
        send_frame(8'hA5, STOP_BIT, 1'b1, -1, 1'b1);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'hA5) begin
            errors++;
            $display("FAIL basic_valid_after_stop: got %b/%h, expected 1/a5", data_valid, data_out);
        end
        idle(1);
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0 || pe_cnt != pe0) begin
            errors++;
            $display("FAIL basic_no_errors: got fe=%0d ov=%0d pe=%0d, expected no new pulses",
                     fe_cnt - fe0, ov_cnt - ov0, pe_cnt - pe0);
        end
        read_word();
        checks++;
        if (data_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_read_clears: got valid=%b pending=%0d, expected 0/0",
                     data_valid, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int ov0 = ov_cnt;
        send_frame(8'h3C, STOP_BIT, 1'b1, -1, 1'b1);
        send_frame(8'hC3, STOP_BIT, 1'b1, 2, 1'b1);
        checks++;
        if (data_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_valid: got %b, expected 1", data_valid);
        end
        read_word();
        idle(1);
        checks++;
        if (ov_cnt != ov0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_no_overrun: got ov=%0d pending=%0d, expected 0/0",
                     ov_cnt - ov0, exp_q.size());
        end
    endtask

    task automatic test_overrun();
        int ov0 = ov_cnt;
        send_frame(8'h11, STOP_BIT, 1'b1, -1, 1'b1);
        idle(2);
        send_frame(8'h22, STOP_BIT, 1'b1, -1, 1'b0);
        idle(3);
        checks++;
        if (ov_cnt - ov0 != 1 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse: got %0d cycles valid=%b, expected 1 cycle valid=1",
                     ov_cnt - ov0, data_valid);
        end
        read_word();
        ov0 = ov_cnt;
        send_frame(8'h11, STOP_BIT, 1'b1, -1, 1'b1);
        idle(1);
        send_frame(8'h22, STOP_BIT, 1'b1, FRAME_LEN - 1, 1'b1);
        idle(1);
        checks++;
        if (ov_cnt != ov0 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_read_same_edge: got ov=%0d valid=%b, expected 0/1",
                     ov_cnt - ov0, data_valid);
        end
        read_word();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL overrun_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_frame_error();
        int fe0 = fe_cnt;
        send_frame(8'h5A, ~STOP_BIT, 1'b1, -1, 1'b0);
        idle(2);
        checks++;
        if (fe_cnt - fe0 != 1 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_error_pulse: got %0d cycles valid=%b, expected 1 cycle valid=0",
                     fe_cnt - fe0, data_valid);
        end
        send_frame(8'h66, STOP_BIT, 1'b1, -1, 1'b1);
        idle(1);
        send_frame(8'h5A, ~STOP_BIT, 1'b1, -1, 1'b0);
        idle(1);
        checks++;
        if (fe_cnt - fe0 != 2 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL frame_error_holds_valid: got %0d pulses valid=%b, expected 2/1",
                     fe_cnt - fe0, data_valid);
        end
        read_word();
        send_frame(8'h99, STOP_BIT, 1'b1, -1, 1'b1);
        idle(1);
        read_word();
        checks++;
        if (exp_q.size() != 0 || fe_cnt - fe0 != 2) begin
            errors++;
            $display("FAIL frame_error_resync: got pending=%0d fe=%0d, expected 0/2",
                     exp_q.size(), fe_cnt - fe0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int fe0 = fe_cnt, ov0 = ov_cnt, pe0 = pe_cnt;
        serial_in = START_BIT; step();
        serial_in = 1'b1; step();
        serial_in = 1'b0; step();
        serial_in = 1'b1; step();
        serial_in = 1'b1; step();
        reset = 1'b1; serial_in = LINE_IDLE; step();
        reset = 1'b0;
        idle(1);
        send_frame(8'h81, STOP_BIT, 1'b1, -1, 1'b1);
        idle(1);
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0 || pe_cnt != pe0 || data_out !== 8'h81) begin
            errors++;
            $display("FAIL reset_mid_frame: got data=%h fe=%0d ov=%0d pe=%0d, expected 81/0/0/0",
                     data_out, fe_cnt - fe0, ov_cnt - ov0, pe_cnt - pe0);
        end
        read_word();
        checks++;
        if (exp_q.size() != 0 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame_drain: got pending=%0d valid=%b, expected 0/0",
                     exp_q.size(), data_valid);
        end
    endtask

    task automatic test_parity();
`ifdef SHIFT_RECEIVER_PARITY_EN
        int pe0 = pe_cnt;
        send_frame(8'h07, STOP_BIT, 1'b0, -1, 1'b0);
        idle(2);
        checks++;
        if (pe_cnt - pe0 != 1 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL parity_bad: got %0d cycles valid=%b, expected 1 cycle valid=0",
                     pe_cnt - pe0, data_valid);
        end
        send_frame(8'h07, STOP_BIT, 1'b1, -1, 1'b1);
        idle(1);
        read_word();
        checks++;
        if (pe_cnt - pe0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL parity_good: got pe=%0d pending=%0d, expected 1/0",
                     pe_cnt - pe0, exp_q.size());
        end
`else
        checks++;
        if (pe_cnt != 0) begin
            errors++;
            $display("FAIL parity_tied_low: got %0d pulses, expected 0", pe_cnt);
        end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_frame_error();
        test_reset_mid_frame();
        test_parity();
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
